// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: drives PC onto the imem port, captures the response and holds it for decode.
// Latency: REQ -> WAIT -> HOLD, so one instruction every 3 cycles at best. Exactly one imem request is outstanding at a time.
// Backpressure: a HOLD stall holds inst/inst_pc and keeps imem_req low. A redirect from execute drops the wrong-path response.
//
// Ports:
//   Clk, reset (async, active-low)
//   imem_req/imem_addr/imem_ready      request side of the instruction memory
//   imem_rvalid/imem_rdata             response side of the instruction memory
//   inst_valid/inst_ready/inst/inst_pc instruction handed to decode
//   redirect_valid/redirect_pc         change of flow from execute
//   fetch_count                        number of instructions delivered to decode (wraps)
module fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            Clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     fetch_count
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // request presented on the imem port
        S_WAIT = 2'd1,  // request accepted, response pending
        S_DROP = 2'd2,  // response pending, but it is on the wrong path
        S_HOLD = 2'd3   // instruction held until decode accepts it
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]     fetch_count_q, fetch_count_d;
    logic [XLEN-1:0] redirect_target;

    // Redirect targets are forced to word alignment. A misaligned target is not flagged.
    assign redirect_target = redirect_pc & ~XLEN'(3);

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            inst_q        <= '0;
            inst_pc_q     <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        fetch_count_d = fetch_count_q;

        // A redirect always reloads the PC, whatever the state. The state then
        // depends on whether a request is still in flight on the imem port.
        if (redirect_valid) begin
            pc_d = redirect_target;
        end

        unique case (state_q)
            S_REQ: begin
                if (imem_ready) begin
                    // Once accepted, the response must be drained even if the path was redirected.
                    state_d = redirect_valid ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    state_d   = S_HOLD;
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    pc_d      = pc_q + XLEN'(4);  // wraps modulo 2^XLEN
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    // The held instruction is on the wrong path. It is discarded and not counted.
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    state_d       = S_REQ;
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    // Suppress valid during a redirect so decode never takes a wrong-path instruction.
    assign inst_valid  = (state_q == S_HOLD) && !redirect_valid;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic        Clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] fetch_count;

    // Second instance whose reset PC sits at the top of the address space
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_imem_ready = 1'b0;
    logic        w_imem_rvalid = 1'b0;
    logic [31:0] w_imem_rdata = '0;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;
    logic [31:0] w_fetch_count;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    logic [31:0] exp_count = '0;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;
    exp_t sb_q[$];

    always #5 Clk = ~Clk;

    fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .Clk(Clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_count(fetch_count)
    );

    fetch_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .Clk(Clk), .reset(reset),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(w_imem_ready),
        .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata),
        .inst_valid(w_inst_valid), .inst_ready(1'b0), .inst(w_inst), .inst_pc(w_inst_pc),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .fetch_count(w_fetch_count)
    );

    // Scoreboard: each decode handshake must deliver the oldest expected instruction.
    always @(negedge Clk) begin
        if (reset && inst_valid && inst_ready) begin
            if (sb_q.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL sb_unexpected: delivered inst=%h pc=%h, required none", inst, inst_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                vec_cnt++;
                if (inst !== e.data) begin
                    miss_cnt++;
                    $display("FAIL sb_inst: got %h, required %h", inst, e.data);
                end
                vec_cnt++;
                if (inst_pc !== e.pc) begin
                    miss_cnt++;
                    $display("FAIL sb_inst_pc: got %h, required %h", inst_pc, e.pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Starts in REQ. Fetches one word and then stalls decode for hold_cycles before it accepts.
    task automatic do_fetch(input logic [31:0] data, input logic [31:0] pc, input int hold_cycles);
        imem_ready = 1'b1;
        tick();                          // -> WAIT
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        sb_q.push_back('{data: data, pc: pc});
        tick();                          // -> HOLD
        imem_rvalid = 1'b0;
        for (int i = 0; i < hold_cycles; i++) begin
            vec_cnt++;
            if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst !== data ||
                inst_pc !== pc || imem_addr !== pc + 32'd4) begin
                miss_cnt++;
                $display("FAIL stall_hold[%0d]: valid=%b req=%b inst=%h pc=%h addr=%h, required 1 0 %h %h %h",
                         i, inst_valid, imem_req, inst, inst_pc, imem_addr, data, pc, pc + 32'd4);
            end
            tick();
        end
        inst_ready = 1'b1;
        tick();                          // handshake -> REQ
        inst_ready = 1'b0;
        exp_count  = exp_count + 32'd1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        reset = 1'b1;
        #1;
        vec_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0 || fetch_count !== 32'h0) begin
            miss_cnt++;
            $display("FAIL reset: req=%b addr=%h valid=%b count=%h, required 1 0 0 0",
                     imem_req, imem_addr, inst_valid, fetch_count);
        end
        vec_cnt++;
        if (inst !== 32'h0 || inst_pc !== 32'h0) begin
            miss_cnt++;
            $display("FAIL reset_inst: inst=%h inst_pc=%h, required 0 0", inst, inst_pc);
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 3; k++) begin
            vec_cnt++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                miss_cnt++;
                $display("FAIL stream_req[%0d]: req=%b addr=%h, required 1 %h", k, imem_req, imem_addr, 32'(4 * k));
            end
            do_fetch(32'hC0DE_0000 + 32'(k), 32'(4 * k), 0);
        end
        vec_cnt++;
        if (fetch_count !== 32'd3) begin
            miss_cnt++;
            $display("FAIL stream_count: got %0d, required 3", fetch_count);
        end
    endtask

    task automatic test_stall();
        do_fetch(32'h1234_5678, 32'h0000_000C, 5);
        vec_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10 || fetch_count !== exp_count) begin
            miss_cnt++;
            $display("FAIL stall_after: req=%b addr=%h count=%0d, required 1 10 %0d",
                     imem_req, imem_addr, fetch_count, exp_count);
        end
    endtask

    task automatic test_redirect_wait();
        imem_ready = 1'b1;
        tick();                          // -> WAIT
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();                          // -> DROP
        redirect_valid = 1'b0;
        vec_cnt++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin
            miss_cnt++;
            $display("FAIL redir_wait_drop: req=%b addr=%h, required 0 100", imem_req, imem_addr);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();                          // response discarded -> REQ
        imem_rvalid = 1'b0;
        vec_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0 || fetch_count !== exp_count) begin
            miss_cnt++;
            $display("FAIL redir_wait: req=%b addr=%h valid=%b count=%0d, required 1 100 0 %0d",
                     imem_req, imem_addr, inst_valid, fetch_count, exp_count);
        end
        // Redirect arrives together with the response, so the response is discarded and we go straight back to REQ.
        imem_ready = 1'b1;
        tick();                          // -> WAIT
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0502;
        imem_rvalid    = 1'b1;
        tick();
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        vec_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h500 || inst_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL redir_wait_same: req=%b addr=%h valid=%b, required 1 500 0",
                     imem_req, imem_addr, inst_valid);
        end
    endtask

    task automatic test_redirect_req();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0301;
        tick();                          // not accepted: stay REQ at new PC
        vec_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            miss_cnt++;
            $display("FAIL redir_req: req=%b addr=%h, required 1 300", imem_req, imem_addr);
        end
        redirect_pc = 32'h0000_0400;
        imem_ready  = 1'b1;
        tick();                          // accepted under redirect -> DROP
        redirect_valid = 1'b0;
        imem_ready     = 1'b0;
        vec_cnt++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h400) begin
            miss_cnt++;
            $display("FAIL redir_req_drop: req=%b addr=%h, required 0 400", imem_req, imem_addr);
        end
        imem_rvalid = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        vec_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h400 || inst_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL redir_req_back: req=%b addr=%h valid=%b, required 1 400 0",
                     imem_req, imem_addr, inst_valid);
        end
        do_fetch(32'hABCD_0400, 32'h0000_0400, 0);
        vec_cnt++;
        if (fetch_count !== exp_count || imem_addr !== 32'h404) begin
            miss_cnt++;
            $display("FAIL redir_req_fetch: count=%0d addr=%h, required %0d 404", fetch_count, imem_addr, exp_count);
        end
    endtask

    task automatic test_redirect_hold();
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_AAAA;
        tick();                          // -> HOLD (not pushed: it will be squashed)
        imem_rvalid    = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0202;
        #1;
        vec_cnt++;
        if (inst_valid !== 1'b0) begin
            miss_cnt++;
            $display("FAIL redir_hold_valid: got %b, required 0", inst_valid);
        end
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        vec_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200 || fetch_count !== exp_count) begin
            miss_cnt++;
            $display("FAIL redir_hold: req=%b addr=%h count=%0d, required 1 200 %0d",
                     imem_req, imem_addr, fetch_count, exp_count);
        end
    endtask

    task automatic test_pc_wrap();
        vec_cnt++;
        if (w_imem_req !== 1'b1 || w_imem_addr !== 32'hFFFF_FFFC) begin
            miss_cnt++;
            $display("FAIL wrap_start: req=%b addr=%h, required 1 fffffffc", w_imem_req, w_imem_addr);
        end
        w_imem_ready = 1'b1;
        tick();
        w_imem_ready  = 1'b0;
        w_imem_rvalid = 1'b1;
        w_imem_rdata  = 32'h0BAD_F00D;
        tick();
        w_imem_rvalid = 1'b0;
        vec_cnt++;
        if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'hFFFF_FFFC || w_imem_addr !== 32'h0 ||
            w_inst !== 32'h0BAD_F00D) begin
            miss_cnt++;
            $display("FAIL wrap: valid=%b inst_pc=%h addr=%h inst=%h, required 1 fffffffc 0 0badf00d",
                     w_inst_valid, w_inst_pc, w_imem_addr, w_inst);
        end
    endtask

    task automatic test_reset_mid();
        imem_ready = 1'b1;
        tick();                          // -> WAIT
        imem_ready = 1'b0;
        vec_cnt++;
        if (imem_req !== 1'b0) begin
            miss_cnt++;
            $display("FAIL rst_mid_pre: req=%b, required 0", imem_req);
        end
        reset = 1'b0;
        #1;
        vec_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0 || fetch_count !== 32'h0) begin
            miss_cnt++;
            $display("FAIL rst_mid: req=%b addr=%h valid=%b count=%h, required 1 0 0 0",
                     imem_req, imem_addr, inst_valid, fetch_count);
        end
        tick();
        reset     = 1'b1;
        exp_count = '0;
        tick();
        vec_cnt++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            miss_cnt++;
            $display("FAIL rst_mid_release: req=%b addr=%h, required 1 0", imem_req, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_req();
        test_redirect_hold();
        test_pc_wrap();
        test_reset_mid();
        vec_cnt++;
        if (sb_q.size() != 0) begin
            miss_cnt++;
            $display("FAIL sb_leftover: %0d entries undelivered, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
